// File: rtl/axis_slot_sequencer.sv
// rtl/axis_slot_sequencer.sv - AXI4-Stream sink that splits a stream into fixed NUM_SLOTS-word packets with slot tagging
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast input stream beat
//   s_axis_tready             input ready (output register empty or draining)
//   m_word_data/valid/ready   registered one-entry output word stage
//   m_slot_onehot/m_slot_idx  slot tag of the held word (one-hot zero when not valid)
//   m_word_last               held word closes its packet
//   busy                      packet in progress
//   pkt_done, pkt_err         one-cycle pulses when a packet closes / framing error
//   pkt_count                 packets closed since reset (wraps)

module axis_slot_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_SLOTS   = 13,
    parameter int IDX_WIDTH   = $clog2(NUM_SLOTS),
    parameter int STRICT_LAST = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_word_data,
    output logic                  m_word_valid,
    input  logic                  m_word_ready,
    output logic [NUM_SLOTS-1:0]  m_slot_onehot,
    output logic [IDX_WIDTH-1:0]  m_slot_idx,
    output logic                  m_word_last,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_SLOT = IDX_WIDTH'(NUM_SLOTS - 1);
    localparam logic [NUM_SLOTS-1:0] ONEHOT_BASE = NUM_SLOTS'(1);

    state_t               state;
    state_t               state_next;
    logic [IDX_WIDTH-1:0] slot;
    logic [IDX_WIDTH-1:0] slot_next;

    logic accept;
    logic at_final;
    logic close;
    logic early_last;
    logic missing_last;

    // The output stage can take a new beat whenever it is empty or its
    // current word leaves in this same cycle, giving one word per cycle.
    assign s_axis_tready = !m_word_valid || m_word_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign at_final      = (slot == LAST_SLOT);

    // A packet closes either on its final slot or on tlast, whichever comes
    // first; an early tlast resynchronises the slot counter to 0.
    assign close        = accept && (at_final || s_axis_tlast);
    assign early_last   = accept && s_axis_tlast && !at_final;
    assign missing_last = (STRICT_LAST != 0) && accept && !s_axis_tlast && at_final;

    assign busy = (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    // The slot counter is always 0 in IDLE, so one increment rule covers
    // both the first beat of a packet and the beats that follow it.
    always_comb begin
        state_next = state;
        slot_next  = slot;
        if (accept) begin
            if (close) begin
                state_next = IDLE;
                slot_next  = '0;
            end else begin
                state_next = ACTIVE;
                slot_next  = slot + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_word_data   <= '0;
            m_word_valid  <= 1'b0;
            m_slot_onehot <= '0;
            m_slot_idx    <= '0;
            m_word_last   <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_err       <= 1'b0;
            pkt_count     <= '0;
        end else begin
            pkt_done <= close;
            pkt_err  <= early_last || missing_last;
            if (close) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            if (accept) begin
                m_word_data   <= s_axis_tdata;
                m_word_valid  <= 1'b1;
                m_slot_onehot <= ONEHOT_BASE << slot;
                m_slot_idx    <= slot;
                m_word_last   <= at_final || s_axis_tlast;
            end else if (m_word_ready) begin
                // Index, data and last may keep stale values once the word
                // has left; only valid and the one-hot strobe must drop.
                m_word_valid  <= 1'b0;
                m_slot_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_slot_sequencer.sv
// tb/tb_axis_slot_sequencer.sv - scoreboard bench for axis_slot_sequencer (13-slot strict and 4-slot relaxed instances)

module tb_axis_slot_sequencer;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  idx;
        logic [12:0] oh;
        logic        last;
        logic        busy;
        logic [15:0] cnt;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance a: NUM_SLOTS=13, STRICT_LAST=1
    logic        a_tvalid = 1'b0;
    logic        a_tlast  = 1'b0;
    logic [63:0] a_tdata  = '0;
    logic        a_mready = 1'b1;
    wire         a_tready, a_mvalid, a_mlast, a_busy, a_done, a_err;
    wire  [63:0] a_mdata;
    wire  [12:0] a_oh;
    wire  [3:0]  a_idx;
    wire  [15:0] a_cnt;

    // instance b: NUM_SLOTS=4, STRICT_LAST=0
    logic        b_tvalid = 1'b0;
    logic        b_tlast  = 1'b0;
    logic [63:0] b_tdata  = '0;
    logic        b_mready = 1'b1;
    wire         b_tready, b_mvalid, b_mlast, b_busy, b_done, b_err;
    wire  [63:0] b_mdata;
    wire  [3:0]  b_oh;
    wire  [1:0]  b_idx;
    wire  [15:0] b_cnt;

    axis_slot_sequencer #(
        .DATA_WIDTH(64), .NUM_SLOTS(13), .STRICT_LAST(1), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
        .m_word_data(a_mdata), .m_word_valid(a_mvalid), .m_word_ready(a_mready),
        .m_slot_onehot(a_oh), .m_slot_idx(a_idx), .m_word_last(a_mlast),
        .busy(a_busy), .pkt_done(a_done), .pkt_err(a_err), .pkt_count(a_cnt)
    );

    axis_slot_sequencer #(
        .DATA_WIDTH(64), .NUM_SLOTS(4), .STRICT_LAST(0), .CNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
        .m_word_data(b_mdata), .m_word_valid(b_mvalid), .m_word_ready(b_mready),
        .m_slot_onehot(b_oh), .m_slot_idx(b_idx), .m_word_last(b_mlast),
        .busy(b_busy), .pkt_done(b_done), .pkt_err(b_err), .pkt_count(b_cnt)
    );

    int    checks = 0;
    int    failures = 0;
    word_t q_a[$];
    word_t q_b[$];
    int    m_slot[2];
    int    exp_cnt[2];
    int    exp_done[2];
    int    exp_err[2];
    int    obs_done[2];
    int    obs_err[2];
    logic  pv[2];
    logic  pr[2];
    word_t pw[2];
    logic  stall_arm = 1'b0;
    logic  rst_hold = 1'b0;
    int    stall_hits = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic snap(input int d, output word_t w, output logic v, output logic r,
                        output logic tr, output logic dn, output logic er);
        if (d == 0) begin
            w  = '{a_mdata, a_idx, a_oh, a_mlast, a_busy, a_cnt};
            v  = a_mvalid; r = a_mready; tr = a_tready; dn = a_done; er = a_err;
        end else begin
            w  = '{b_mdata, {2'b00, b_idx}, {9'd0, b_oh}, b_mlast, b_busy, b_cnt};
            v  = b_mvalid; r = b_mready; tr = b_tready; dn = b_done; er = b_err;
        end
    endtask

    task automatic mon_step(input int d);
        word_t w, e;
        logic  v, r, tr, dn, er;
        snap(d, w, v, r, tr, dn, er);
        if (rst) begin
            pv[d] = 1'b0;
            return;
        end
        if (dn) obs_done[d]++;
        if (er) begin
            obs_err[d]++;
            check_eq($sformatf("err_with_done%0d", d), 128'(dn), 128'(1));
        end
        if (!v) check_eq($sformatf("onehot_idle%0d", d), 128'(w.oh), 128'(0));
        if (pv[d] && !pr[d]) begin
            check_eq($sformatf("hold_valid%0d", d), 128'(v), 128'(1));
            check_eq($sformatf("hold_word%0d", d), 128'(w), 128'(pw[d]));
        end
        if (v && !r) check_eq($sformatf("tready_stall%0d", d), 128'(tr), 128'(0));
        if (v && r) begin
            check_eq($sformatf("word_present%0d", d), 128'(qsize(d) > 0), 128'(1));
            if (qsize(d) > 0) begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                check_eq($sformatf("word%0d", d), 128'(w), 128'(e));
            end
        end
        pv[d] = v;
        pr[d] = r;
        pw[d] = w;
    endtask

    always begin
        @(negedge clk);
        #4;
        mon_step(0);
        mon_step(1);
    end

    // sole driver of a_mready: a one-shot 3-cycle stall on slot 4, or a hold for the reset test
    always begin
        @(negedge clk);
        if (rst_hold) begin
            a_mready = 1'b0;
        end else if (stall_arm && a_mvalid && a_idx == 4'd4) begin
            stall_arm = 1'b0;
            stall_hits++;
            a_mready = 1'b0;
            repeat (3) @(negedge clk);
            a_mready = 1'b1;
        end else begin
            a_mready = 1'b1;
        end
    end

    task automatic set_in(input int d, input logic v, input logic [63:0] data, input logic l);
        if (d == 0) begin
            a_tvalid = v; a_tdata = data; a_tlast = l;
        end else begin
            b_tvalid = v; b_tdata = data; b_tlast = l;
        end
    endtask

    task automatic send(input int d, input logic [63:0] data, input logic last);
        int    n;
        int    ns;
        logic  tr;
        logic  err;
        word_t e;
        ns = (d == 0) ? 13 : 4;
        n  = 0;
        @(negedge clk);
        set_in(d, 1'b1, data, last);
        forever begin
            #4;
            tr = (d == 0) ? a_tready : b_tready;
            if (tr || n >= 50) break;
            n++;
            @(negedge clk);
        end
        check_eq($sformatf("accept_in_time%0d", d), 128'(tr), 128'(1));
        if (d == 1) check_eq("b_no_bubble", 128'(n), 128'(0));
        if (tr) begin
            e.data = data;
            e.idx  = 4'(m_slot[d]);
            e.oh   = 13'b1 << m_slot[d];
            e.last = (m_slot[d] == ns - 1) || last;
            err    = (last && m_slot[d] < ns - 1) || (!last && m_slot[d] == ns - 1 && d == 0);
            if (e.last) begin
                m_slot[d] = 0;
                exp_cnt[d]++;
                exp_done[d]++;
                if (err) exp_err[d]++;
            end else begin
                m_slot[d]++;
            end
            e.busy = !e.last;
            e.cnt  = 16'(exp_cnt[d]);
            if (d == 0) q_a.push_back(e);
            else q_b.push_back(e);
            @(posedge clk);
        end
        #1;
        set_in(d, 1'b0, data, 1'b0);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("drain%0d", d), 128'(qsize(d)), 128'(0));
        repeat (2) @(negedge clk);
        check_eq($sformatf("done_count%0d", d), 128'(obs_done[d]), 128'(exp_done[d]));
        check_eq($sformatf("err_count%0d", d), 128'(obs_err[d]), 128'(exp_err[d]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 128'(a_mvalid), 128'(0));
        check_eq("rst_onehot", 128'(a_oh), 128'(0));
        check_eq("rst_busy", 128'(a_busy), 128'(0));
        check_eq("rst_count", 128'(a_cnt), 128'(0));
        check_eq("rst_pulses", 128'({a_done, a_err, a_mlast}), 128'(0));
        check_eq("rst_b_valid", 128'({b_mvalid, b_busy, b_cnt}), 128'(0));
        rst = 1'b0;

        // full 13-word packet, no backpressure
        for (int i = 0; i < 13; i++) send(0, 64'(256 + i), i == 12);
        drain(0);
        check_eq("pkt_count_1", 128'(a_cnt), 128'(1));

        // same packet with a 3-cycle stall on slot 4
        stall_arm = 1'b1;
        for (int i = 0; i < 13; i++) send(0, 64'(256 + i), i == 12);
        drain(0);
        check_eq("stall_applied", 128'(stall_hits), 128'(1));
        check_eq("pkt_count_2", 128'(a_cnt), 128'(2));

        // early tlast on slot 4, then 13 beats without tlast, then an early tlast on slot 0
        for (int i = 0; i < 5; i++) send(0, 64'(512 + i), i == 4);
        for (int i = 0; i < 13; i++) send(0, 64'(768 + i), 1'b0);
        send(0, 64'h3ff, 1'b1);
        drain(0);
        check_eq("pkt_count_5", 128'(a_cnt), 128'(5));

        // 4-slot relaxed instance: 3 back-to-back packets, then one without tlast
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) send(1, 64'(1024 + p * 16 + i), i == 3);
        for (int i = 0; i < 4; i++) send(1, 64'(1280 + i), 1'b0);
        drain(1);
        check_eq("b_pkt_count", 128'(b_cnt), 128'(4));
        check_eq("b_busy_end", 128'(b_busy), 128'(0));

        // reset in the middle of a packet with slot 6 held
        for (int i = 0; i < 7; i++) send(0, 64'(1536 + i), 1'b0);
        rst_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("held_before_rst", 128'({a_mvalid, a_idx}), 128'({1'b1, 4'd6}));
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_valid", 128'(a_mvalid), 128'(0));
        check_eq("abort_busy", 128'(a_busy), 128'(0));
        check_eq("abort_count", 128'(a_cnt), 128'(0));
        q_a.delete();
        q_b.delete();
        for (int d = 0; d < 2; d++) begin
            m_slot[d]  = 0;
            exp_cnt[d] = 0;
        end
        rst = 1'b0;
        rst_hold = 1'b0;
        for (int i = 0; i < 13; i++) send(0, 64'(1792 + i), i == 12);
        drain(0);
        check_eq("pkt_count_after_rst", 128'(a_cnt), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_slot_sequencer.md
Name: axis_slot_sequencer

Overview:
- Parametrised AXI4-Stream sink that splits an input stream into fixed-length packets of NUM_SLOTS words.
- Tags each word with a one-hot slot strobe and a binary slot index, and presents it through a one-entry registered output stage with full-throughput backpressure.
- Sits between the DMA stream and the per-slot feature/clause load registers of the inference core.
- Adds packet framing checks, packet-done/error pulses and a packet counter.

Parameters:
- DATA_WIDTH, 64, width of the stream data word.
- NUM_SLOTS, 13, words per packet (must be >= 2).
- IDX_WIDTH, $clog2(NUM_SLOTS), width of the slot index (derived; do not override).
- STRICT_LAST, 1, when 1 a missing tlast on the final slot is flagged as an error.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end-of-packet marker.
- m_word_data  out  DATA_WIDTH  registered output word.
- m_word_valid  out  1  output word valid.
- m_word_ready  in  1  downstream accept.
- m_slot_onehot  out  NUM_SLOTS  one-hot slot of the held word; all-zero when m_word_valid=0.
- m_slot_idx  out  IDX_WIDTH  binary slot of the held word.
- m_word_last  out  1  held word is the final word of its packet.
- busy  out  1  packet in progress (at least one word accepted, packet not closed).
- pkt_done  out  1  one-cycle pulse when a packet closes.
- pkt_err  out  1  one-cycle pulse on a framing error.
- pkt_count  out  CNT_WIDTH  packets closed since reset; wraps.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0. Slot counter 0, state IDLE. A held output word is discarded. Reset overrides any accept in the same cycle.
- Input accept: s_axis_tready = !m_word_valid || m_word_ready (combinational). A beat is accepted when s_axis_tvalid && s_axis_tready.
- Latency: an accepted beat appears on m_word_* on the next cycle. Sustained one word per cycle when m_word_ready=1.
- Output register:
  - Loads on accept.
  - Clears m_word_valid and m_slot_onehot when m_word_ready=1 and no new accept occurs.
  - Holds every m_word_* output stable while m_word_valid && !m_word_ready.
- Tagging: on accept, m_slot_idx = slot counter, m_slot_onehot = 1 << slot counter. m_word_last = 1 when slot counter = NUM_SLOTS-1 or tlast=1.
- State machine:
  - IDLE: slot counter 0. An accept moves to ACTIVE, unless that beat closes the packet.
  - ACTIVE: each accept increments the slot counter.
  - Close: an accept with slot counter = NUM_SLOTS-1, or with tlast=1, closes the packet. Closing sets the slot counter to 0 (wrap), returns to IDLE, pulses pkt_done the next cycle, and increments pkt_count.
- Framing errors (pkt_err pulses the cycle after the accept, coincident with pkt_done):
  - tlast=1 at slot < NUM_SLOTS-1: early last. The packet closes and the counter resynchronises to 0.
  - tlast=0 at slot NUM_SLOTS-1 with STRICT_LAST=1: missing last. The packet still closes. With STRICT_LAST=0, no error.
- busy = state ACTIVE.
- pkt_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Idle gaps (tvalid=0) anywhere within a packet are legal and do not affect the slot counter.

Test Plan:
- NUM_SLOTS=13, 13 beats (data 0x100..0x10C, tlast on the 13th), m_word_ready=1 → m_slot_idx 0..12, one-hot 0x0001..0x1000. m_word_last only on 0x10C. pkt_done pulses once, pkt_count=1, pkt_err never asserted.
- Same packet with m_word_ready low for 3 cycles at slot 4 → s_axis_tready=0 for those cycles, word 0x104/slot 4 held stable, no loss or duplication, pkt_count=1.
- tlast on beat 5 (slot 4) → pkt_err and pkt_done pulse together, m_word_last=1 on slot 4. The next beat is tagged slot 0.
- STRICT_LAST=1, 13 beats with no tlast → pkt_err and pkt_done after slot 12, the 14th beat is slot 0. Repeat with STRICT_LAST=0 → pkt_done only.
- NUM_SLOTS=4, 3 back-to-back packets → slots 0,1,2,3 repeating with no bubble, pkt_count=3, busy deasserts after each slot 3.
- Reset asserted after slot 6 with a word held and m_word_ready=0 → next cycle m_word_valid=0, busy=0, pkt_count=0. The next accepted beat is slot 0 and no pkt_done is generated for the aborted packet.
